rgbw_pwm: RTL and testbench

RGBW_PWM -- requirements
Module: rgbw_pwm

---
 rtl/rgbw_pkg.sv | 13 +
 rtl/rgbw_pwm_if.sv | 34 +++
 rtl/rgbw_pwm_channel.sv | 30 +++
 rtl/rgbw_pwm.sv | 132 +++++++++++++
 tb/tb_rgbw_pwm.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgbw_pkg.sv
// RGBW PWM shared constants and FSM encoding.
// Imported by the top and the per-channel comparator.
package rgbw_pkg;

  localparam logic [7:0] PWM_TOP    = 8'd254;
  localparam logic [7:0] PHASE_STEP = 8'd64;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/rgbw_pwm_if.sv
// Colour-generator side bundle of the RGBW PWM block.
// master drives duties/strobes, slave is the PWM engine.
interface rgbw_pwm_if;

  logic       en;
  logic       load;
  logic [7:0] redIn;
  logic [7:0] greenIn;
  logic [7:0] blueIn;
  logic [7:0] whiteIn;
  logic [7:0] prescIn;
  logic       redPwm;
  logic       greenPwm;
  logic       bluePwm;
  logic       whitePwm;
  logic       pending;
  logic       applied;
  logic       periodStart;

  modport master (
    output en, load, redIn, greenIn, blueIn,
    output whiteIn, prescIn,
    input  redPwm, greenPwm, bluePwm, whitePwm,
    input  pending, applied, periodStart
  );

  modport slave (
    input  en, load, redIn, greenIn, blueIn,
    input  whiteIn, prescIn,
    output redPwm, greenPwm, bluePwm, whitePwm,
    output pending, applied, periodStart
  );

endinterface

// File: rtl/rgbw_pwm_channel.sv
// One PWM channel: phase offset, mod-255 wrap,
// duty compare and registered output.
module pwm_channel
  import rgbw_pkg::*;
#(
  parameter bit STAGGER = 1'b1,
  parameter int K       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] cnt,
  input  logic [7:0] duty,
  output logic       pwm
);

  localparam logic [8:0] OFS =
    STAGGER ? 9'(K) * {1'b0, PHASE_STEP} : 9'd0;

  logic [8:0] sum;
  logic [7:0] ph;

  assign sum = {1'b0, cnt} + OFS;
  assign ph  = 8'((sum >= 9'd255) ? sum - 9'd255 : sum);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= en && (ph < duty);

endmodule

// File: rtl/rgbw_pwm.sv
// Four-channel RGBW PWM with shadowed duties/prescaler
// that switch over only on a period boundary.
module rgbw_pwm
  import rgbw_pkg::*;
#(
  parameter bit         PHASE_STAGGER = 1'b1,
  parameter logic [7:0] PRESC_RST     = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] redIn,
  input  logic [7:0] greenIn,
  input  logic [7:0] blueIn,
  input  logic [7:0] whiteIn,
  input  logic [7:0] prescIn,
  output logic       redPwm,
  output logic       greenPwm,
  output logic       bluePwm,
  output logic       whitePwm,
  output logic       pending,
  output logic       applied,
  output logic       periodStart
);

  logic [1:0] rsync;
  logic       rst_n;

  // assert asynchronously, release two edges later
  always_ff @(posedge clk or negedge reset)
    if (!reset) rsync <= 2'b00;
    else        rsync <= {rsync[0], 1'b1};

  assign rst_n = rsync[1];

  logic [7:0] din [4];
  logic [7:0] shd [4];
  logic [7:0] act [4];
  logic [7:0] presc_shd;
  logic [7:0] presc_act;
  logic [7:0] pc;
  logic [7:0] cnt;
  logic       tick;
  logic       boundary;
  logic       copy;
  logic [3:0] pwm;
  state_t     state;
  state_t     nxt;

  assign din[0] = redIn;
  assign din[1] = greenIn;
  assign din[2] = blueIn;
  assign din[3] = whiteIn;

  assign tick     = en && (pc == presc_act);
  assign boundary = tick && (cnt == PWM_TOP);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc  <= 8'd0;
      cnt <= 8'd0;
    end else if (!en) begin
      pc  <= 8'd0;
      cnt <= 8'd0;
    end else if (tick) begin
      pc  <= 8'd0;
      cnt <= (cnt == PWM_TOP) ? 8'd0 : cnt + 8'd1;
    end else begin
      pc  <= pc + 8'd1;
    end

  // a load always wins over a pending copy
  always_comb begin
    nxt  = state;
    copy = 1'b0;
    unique case (state)
      IDLE: if (load) nxt = PEND;
      PEND: if (!load && (boundary || !en)) begin
        nxt  = IDLE;
        copy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      presc_shd   <= PRESC_RST;
      presc_act   <= PRESC_RST;
      applied     <= 1'b0;
      periodStart <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        shd[k] <= 8'd0;
        act[k] <= 8'd0;
      end
    end else begin
      state       <= nxt;
      applied     <= copy;
      periodStart <= boundary;
      if (load) begin
        presc_shd <= prescIn;
        for (int k = 0; k < 4; k++) shd[k] <= din[k];
      end
      if (copy) begin
        presc_act <= presc_shd;
        for (int k = 0; k < 4; k++) act[k] <= shd[k];
      end
    end

  assign pending = (state == PEND);

  for (genvar k = 0; k < 4; k++) begin : g_ch
    pwm_channel #(
      .STAGGER (PHASE_STAGGER),
      .K       (k)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .cnt   (cnt),
      .duty  (act[k]),
      .pwm   (pwm[k])
    );
  end

  assign redPwm   = pwm[0];
  assign greenPwm = pwm[1];
  assign bluePwm  = pwm[2];
  assign whitePwm = pwm[3];

endmodule

// File: tb/tb_rgbw_pwm.sv
// Bench for rgbw_pwm: aligned and staggered instances run
// side by side against a time-arithmetic reference model.
module tb_rgbw_pwm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rgbw_pwm_if s0 ();
  rgbw_pwm_if s1 ();

  assign s1.en      = s0.en;
  assign s1.load    = s0.load;
  assign s1.redIn   = s0.redIn;
  assign s1.greenIn = s0.greenIn;
  assign s1.blueIn  = s0.blueIn;
  assign s1.whiteIn = s0.whiteIn;
  assign s1.prescIn = s0.prescIn;

  rgbw_pwm #(.PHASE_STAGGER(1'b0), .PRESC_RST(8'd0)) dut0 (
    .clk(clk), .reset(reset), .en(s0.en), .load(s0.load),
    .redIn(s0.redIn), .greenIn(s0.greenIn),
    .blueIn(s0.blueIn), .whiteIn(s0.whiteIn),
    .prescIn(s0.prescIn),
    .redPwm(s0.redPwm), .greenPwm(s0.greenPwm),
    .bluePwm(s0.bluePwm), .whitePwm(s0.whitePwm),
    .pending(s0.pending), .applied(s0.applied),
    .periodStart(s0.periodStart)
  );

  rgbw_pwm #(.PHASE_STAGGER(1'b1), .PRESC_RST(8'd1)) dut1 (
    .clk(clk), .reset(reset), .en(s1.en), .load(s1.load),
    .redIn(s1.redIn), .greenIn(s1.greenIn),
    .blueIn(s1.blueIn), .whiteIn(s1.whiteIn),
    .prescIn(s1.prescIn),
    .redPwm(s1.redPwm), .greenPwm(s1.greenPwm),
    .bluePwm(s1.bluePwm), .whitePwm(s1.whitePwm),
    .pending(s1.pending), .applied(s1.applied),
    .periodStart(s1.periodStart)
  );

  int checks = 0;
  int failures = 0;
  int ncyc = 0;

  // model: mc = clocks since the current period began
  int mc [2];
  int pa [2];
  int sp [2];
  int act [2][4];
  int shd [2][4];
  bit pend [2];
  logic [6:0] ex [2];

  int hi [2][4];
  int app_n = 0;
  int ps_q [$];

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0;
      pa[i] = i;
      sp[i] = i;
      pend[i] = 1'b0;
      ex[i] = '0;
      for (int k = 0; k < 4; k++) begin
        act[i][k] = 0;
        shd[i][k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        int c;
        int ph;
        bit tk;
        bit bd;
        bit cp;
        logic [3:0] pw;
        c  = mc[i] / (pa[i] + 1);
        tk = s0.en && (mc[i] % (pa[i] + 1) == pa[i]);
        bd = tk && (c == 254);
        for (int k = 0; k < 4; k++) begin
          ph = (i == 1) ? (c + 64 * k) % 255 : c;
          pw[3-k] = s0.en && (ph < act[i][k]);
        end
        cp = pend[i] && !s0.load && (bd || !s0.en);
        mc[i] = (!s0.en || bd) ? 0 : mc[i] + 1;
        if (s0.load) begin
          shd[i][0] = s0.redIn;
          shd[i][1] = s0.greenIn;
          shd[i][2] = s0.blueIn;
          shd[i][3] = s0.whiteIn;
          sp[i] = s0.prescIn;
          pend[i] = 1'b1;
        end else if (cp) begin
          for (int k = 0; k < 4; k++) act[i][k] = shd[i][k];
          pa[i] = sp[i];
          pend[i] = 1'b0;
        end
        ex[i] = {pw, pend[i], cp, bd};
      end
    end
  end

  function automatic bit will_bd();
    return s0.en && (mc[0] % (pa[0] + 1) == pa[0])
                 && (mc[0] / (pa[0] + 1) == 254);
  endfunction

  task automatic cyc(int n);
    logic [6:0] o0;
    logic [6:0] o1;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      ncyc++;
      o0 = {s0.redPwm, s0.greenPwm, s0.bluePwm,
            s0.whitePwm, s0.pending, s0.applied,
            s0.periodStart};
      o1 = {s1.redPwm, s1.greenPwm, s1.bluePwm,
            s1.whitePwm, s1.pending, s1.applied,
            s1.periodStart};
      chk($sformatf("aligned@%0d", ncyc), int'(o0), int'(ex[0]));
      chk($sformatf("stagger@%0d", ncyc), int'(o1), int'(ex[1]));
      for (int k = 0; k < 4; k++) begin
        hi[0][k] += int'(o0[6-k]);
        hi[1][k] += int'(o1[6-k]);
      end
      app_n += int'(s0.applied);
      if (s0.periodStart) ps_q.push_back(ncyc);
    end
  endtask

  task automatic win(int n);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) hi[i][k] = 0;
    cyc(n);
  endtask

  task automatic ld(int r, int g, int b, int w, int p);
    s0.redIn   = 8'(r);
    s0.greenIn = 8'(g);
    s0.blueIn  = 8'(b);
    s0.whiteIn = 8'(w);
    s0.prescIn = 8'(p);
    s0.load    = 1'b1;
    cyc(1);
    s0.load    = 1'b0;
  endtask

  task automatic wait_bd();
    int j;
    j = 0;
    while (!will_bd() && j < 2000) begin
      cyc(1);
      j++;
    end
    chk("boundary_timeout", int'(will_bd()), 1);
  endtask

  task automatic wait_ps(int need);
    for (int j = 0; j < 3000 && ps_q.size() < need; j++) cyc(1);
    chk("period_timeout", int'(ps_q.size() >= need), 1);
  endtask

  initial begin
    #100_000_0;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d [4];
    s0.en = 1'b0;
    s0.load = 1'b0;
    s0.redIn = '0;
    s0.greenIn = '0;
    s0.blueIn = '0;
    s0.whiteIn = '0;
    s0.prescIn = '0;
    #1 reset = 1'b0;
    model_reset();
    #2;
    chk("reset_out0", int'({s0.redPwm, s0.greenPwm, s0.bluePwm,
        s0.whitePwm, s0.pending, s0.applied, s0.periodStart}), 0);
    chk("reset_out1", int'({s1.redPwm, s1.greenPwm, s1.bluePwm,
        s1.whitePwm, s1.pending, s1.applied, s1.periodStart}), 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(4);

    // red 128, presc 0
    s0.en = 1'b1;
    ld(128, 0, 0, 0, 0);
    chk("pending_set", int'(s0.pending), 1);
    cyc(600);
    win(255);
    chk("red128_hi", hi[0][0], 128);
    chk("green_off", hi[0][1], 0);
    chk("blue_off", hi[0][2], 0);
    chk("white_off", hi[0][3], 0);
    chk("stag_red128", hi[1][0], 128);

    // boundary duties over 3 periods
    ld(37, 0, 255, 200, 0);
    cyc(600);
    win(765);
    chk("green0", hi[0][1], 0);
    chk("blue255", hi[0][2], 765);
    chk("red37", hi[0][0], 111);
    chk("white200", hi[0][3], 600);
    chk("stag_blue255", hi[1][2], 765);
    chk("stag_green0", hi[1][1], 0);

    // staggered, all 64
    ld(64, 64, 64, 64, 0);
    cyc(600);
    win(255);
    for (int k = 0; k < 4; k++)
      chk($sformatf("stag64_ch%0d", k), hi[1][k], 64);

    // three loads, last one on the boundary cycle
    wait_bd();
    cyc(100);
    app_n = 0;
    ld(10, 20, 30, 40, 0);
    cyc(50);
    ld(50, 60, 70, 80, 0);
    wait_bd();
    ld(100, 150, 200, 250, 0);
    cyc(250);
    chk("no_early_apply", app_n, 0);
    chk("still_pending", int'(s0.pending), 1);
    cyc(350);
    chk("one_apply", app_n, 1);
    win(255);
    d = '{100, 150, 200, 250};
    for (int k = 0; k < 4; k++)
      chk($sformatf("third_val_ch%0d", k), hi[0][k], d[k]);

    // prescaler 3, then back to 0 mid-period
    ld(128, 0, 0, 0, 3);
    cyc(300);
    ps_q.delete();
    wait_ps(2);
    if (ps_q.size() >= 2)
      chk("period1020", ps_q[1] - ps_q[0], 1020);
    ps_q.delete();
    wait_ps(1);
    cyc(400);
    ld(128, 0, 0, 0, 0);
    wait_ps(3);
    if (ps_q.size() >= 3) begin
      chk("old_period_kept", ps_q[1] - ps_q[0], 1020);
      chk("new_period255", ps_q[2] - ps_q[1], 255);
    end

    // en low applies a pending load at once
    app_n = 0;
    ld($urandom_range(1, 254), $urandom_range(0, 255),
       $urandom_range(0, 255), $urandom_range(0, 255), 0);
    s0.en = 1'b0;
    cyc(10);
    chk("en0_apply", app_n, 1);
    chk("en0_pwm", int'({s0.redPwm, s0.bluePwm}), 0);
    s0.en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      ld($urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 1));
      cyc($urandom_range(50, 700));
    end

    // async reset with outputs high
    ld(255, 255, 255, 255, 0);
    cyc(600);
    chk("high_before_rst", int'({s0.redPwm, s1.whitePwm}), 3);
    #2 reset = 1'b0;
    s0.en = 1'b0;
    model_reset();
    #1;
    chk("async_rst0", int'({s0.redPwm, s0.greenPwm, s0.bluePwm,
        s0.whitePwm, s0.pending, s0.applied, s0.periodStart}), 0);
    chk("async_rst1", int'({s1.redPwm, s1.greenPwm, s1.bluePwm,
        s1.whitePwm, s1.pending, s1.applied, s1.periodStart}), 0);
    cyc(3);
    reset = 1'b1;
    cyc(4);
    s0.en = 1'b1;
    win(600);
    for (int k = 0; k < 4; k++)
      chk($sformatf("post_rst_ch%0d", k), hi[0][k] + hi[1][k], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
